// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the IFU/LSU memory port arbiter.
// Imported by the interface, the timeout counter and the arbiter top.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W         = 32'd32;
    localparam int DEF_DATA_W         = 32'd32;
    localparam int DEF_TIMEOUT_CYCLES = 32'd1023;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_ERR   = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus bundle shared by the IFU, the LSU and the memory slave.
// The master modport issues requests and consumes responses; the slave modport is the mirror image.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32'd32,
    parameter int DATA_W = 32'd32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     addr;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     rdata;
    logic                  resp_err;

    modport master (
        output req_valid, addr, wen, wdata, wmask, resp_ready,
        input  req_ready, resp_valid, rdata, resp_err
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask, resp_ready,
        output req_ready, resp_valid, rdata, resp_err
    );
endinterface

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Saturating response-wait counter; expired flags the cycle in which the count reaches LIMIT.
// LIMIT = 0 disables expiry entirely.
module arb_timeout_cnt #(
    parameter int LIMIT = 32'd1023
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count silent cycles, holding at LIMIT and clearing on request.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && (cnt_r != LIMIT_C)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry is announced in the cycle whose increment would land on LIMIT.
    always_comb begin
        expired = (LIMIT != 0) && enable && (cnt_r == LAST_C);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU with round-robin grant,
// a single outstanding transaction, and a timeout that turns a stalled slave into an error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   ifu,
    mem_port_arbiter_if.slave   lsu,
    mem_port_arbiter_if.master  mem
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e state_r, state_next_s;
    owner_e     owner_r, owner_next_s;
    owner_e     last_grant_r, last_grant_next_s;
    logic       owner_resp_ready_s;
    logic       tmo_clear_s;
    logic       tmo_en_s;
    logic       tmo_expired_s;
    logic       ifu_unused_s;

    // The IFU never writes, so its write fields are deliberately ignored.
    assign ifu_unused_s = ^{ifu.wen, ifu.wdata, ifu.wmask};

    // Wait counter runs only in RESP while the slave stays silent.
    always_comb begin
        tmo_clear_s = (state_r != ST_RESP);
        tmo_en_s    = (state_r == ST_RESP) && !mem.resp_valid;
    end

    arb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmo_clear_s),
        .enable  (tmo_en_s),
        .expired (tmo_expired_s)
    );

    // State, owner and round-robin history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWNER_IFU;
            last_grant_r <= OWNER_IFU;
        end else begin
            state_r      <= state_next_s;
            owner_r      <= owner_next_s;
            last_grant_r <= last_grant_next_s;
        end
    end

    // Next-state, grant and bus steering; everything idles to zero while reset is high.
    always_comb begin
        state_next_s      = state_r;
        owner_next_s      = owner_r;
        last_grant_next_s = last_grant_r;
        owner_resp_ready_s = (owner_r == OWNER_LSU) ? lsu.resp_ready : ifu.resp_ready;

        ifu.req_ready  = 1'b0;
        ifu.resp_valid = 1'b0;
        ifu.rdata      = {DATA_W{1'b0}};
        ifu.resp_err   = 1'b0;
        lsu.req_ready  = 1'b0;
        lsu.resp_valid = 1'b0;
        lsu.rdata      = {DATA_W{1'b0}};
        lsu.resp_err   = 1'b0;
        mem.req_valid  = 1'b0;
        mem.addr       = {ADDR_W{1'b0}};
        mem.wen        = 1'b0;
        mem.wdata      = {DATA_W{1'b0}};
        mem.wmask      = {STRB_W{1'b0}};
        mem.resp_ready = 1'b0;

        if (reset) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // LSU wins when alone, or in a conflict after an IFU grant.
                    if (lsu.req_valid && (!ifu.req_valid || (last_grant_r == OWNER_IFU))) begin
                        mem.req_valid     = 1'b1;
                        mem.addr          = lsu.addr;
                        mem.wen           = lsu.wen;
                        mem.wdata         = lsu.wdata;
                        mem.wmask         = lsu.wmask;
                        lsu.req_ready     = mem.req_ready;
                        owner_next_s      = OWNER_LSU;
                        last_grant_next_s = OWNER_LSU;
                        state_next_s      = mem.req_ready ? ST_RESP : ST_REQ;
                    end else if (ifu.req_valid) begin
                        mem.req_valid     = 1'b1;
                        mem.addr          = ifu.addr;
                        ifu.req_ready     = mem.req_ready;
                        owner_next_s      = OWNER_IFU;
                        last_grant_next_s = OWNER_IFU;
                        state_next_s      = mem.req_ready ? ST_RESP : ST_REQ;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    mem.req_valid = 1'b1;
                    if (owner_r == OWNER_LSU) begin
                        mem.addr      = lsu.addr;
                        mem.wen       = lsu.wen;
                        mem.wdata     = lsu.wdata;
                        mem.wmask     = lsu.wmask;
                        lsu.req_ready = mem.req_ready;
                    end else begin
                        mem.addr      = ifu.addr;
                        ifu.req_ready = mem.req_ready;
                    end
                    state_next_s = mem.req_ready ? ST_RESP : ST_REQ;
                end
                ST_RESP: begin
                    if (owner_r == OWNER_LSU) begin
                        lsu.resp_valid = mem.resp_valid;
                        lsu.rdata      = mem.rdata;
                        lsu.resp_err   = mem.resp_err;
                    end else begin
                        ifu.resp_valid = mem.resp_valid;
                        ifu.rdata      = mem.rdata;
                        ifu.resp_err   = mem.resp_err;
                    end
                    mem.resp_ready = owner_resp_ready_s;
                    // A real response in the expiry cycle takes priority over the timeout.
                    if (mem.resp_valid && owner_resp_ready_s) begin
                        state_next_s = ST_IDLE;
                    end else if (!mem.resp_valid && tmo_expired_s) begin
                        state_next_s = ST_ERR;
                    end else begin
                        state_next_s = ST_RESP;
                    end
                end
                ST_ERR: begin
                    if (owner_r == OWNER_LSU) begin
                        lsu.resp_valid = 1'b1;
                        lsu.resp_err   = 1'b1;
                    end else begin
                        ifu.resp_valid = 1'b1;
                        ifu.resp_err   = 1'b1;
                    end
                    state_next_s = owner_resp_ready_s ? ST_DRAIN : ST_ERR;
                end
                ST_DRAIN: begin
                    // Swallow the late slave response; waits forever if none ever comes.
                    mem.resp_ready = 1'b1;
                    state_next_s   = mem.resp_valid ? ST_IDLE : ST_DRAIN;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

endmodule
